// File: rtl/lcd_hd44780_responder_if.sv
// 8-bit HD44780-style LCD bus: the controller drives rs/rw/enable/data, and the
// responder receives them.
interface lcd_hd44780_responder_if;
  logic       rs;
  logic       rw;
  logic       enable;
  logic [7:0] data;

  modport master (output rs, rw, enable, data);
  modport slave  (input  rs, rw, enable, data);
endinterface

// File: rtl/lcd_hd44780_responder.sv
// Receiving end of the HD44780 LCD bus. It latches writes on the enable falling edge,
// decodes instructions and data, and keeps DDRAM, CGRAM, the AC and the mode flags.
module lcd_hd44780_responder #(
  parameter int unsigned SYNC_STAGES = 2,   // must be >= 2
  parameter logic [7:0]  CLEAR_FILL  = 8'h20
) (
  input  logic                          clk,
  input  logic                          reset,
  lcd_hd44780_responder_if.slave        bus,
  input  logic [6:0]                    rd_addr,
  input  logic [5:0]                    cg_rd_addr,
  output logic [7:0]                    rd_data,
  output logic [4:0]                    cg_rd_data,
  output logic [6:0]                    addr_counter,
  output logic                          cgram_mode,
  output logic                          display_on,
  output logic                          cursor_on,
  output logic                          blink_on,
  output logic                          func_dl,
  output logic                          func_n,
  output logic                          entry_id,
  output logic                          busy,
  output logic                          overrun
);

  localparam logic [6:0] LAST_IDX = 7'd79;

  typedef enum logic {
    ST_IDLE,
    ST_CLEARING
  } state_e;

  state_e state_q, state_d;
  logic [6:0] clr_idx_q, clr_idx_d;
  logic [6:0] ac_q, ac_d;
  logic       cgram_q, cgram_d;
  logic       disp_q, disp_d;
  logic       cur_q, cur_d;
  logic       blink_q, blink_d;
  logic       dl_q, dl_d;
  logic       n_q, n_d;
  logic       id_q, id_d;
  logic       ovr_q, ovr_d;

  logic [SYNC_STAGES-1:0]       en_sync_q;
  logic                         en_prev_q;
  logic [SYNC_STAGES-1:0][9:0]  bus_dly_q;

  logic [7:0] mem_q [80];
  logic [4:0] cg_q  [64];
  logic [5:0] cg_rst_idx_q;
  logic [7:0] rd_data_q;
  logic [4:0] cg_rd_data_q;

  logic       strobe;
  logic       strb_rs, strb_rw;
  logic [7:0] strb_data;
  logic [7:0] wmap, rmap;

  logic       dd_we;
  logic [6:0] dd_widx;
  logic [7:0] dd_wdata;
  logic       cg_we;
  logic [5:0] cg_widx;
  logic [4:0] cg_wdata;

  // Returns {valid, cell index} for a raw HD44780 DDRAM address.
  function automatic logic [7:0] dd_map(input logic [6:0] a);
    if (a <= 7'h27)                    return {1'b1, a};
    else if (a >= 7'h40 && a <= 7'h67) return {1'b1, a - 7'h18};
    else                               return 8'h00;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic cg, input logic inc);
    if (cg)       return {1'b0, inc ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
    else if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else          return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
  endfunction

  // rs/rw/data are delayed by the same depth as enable, so they stay aligned with the detected edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en_sync_q <= '0;
      en_prev_q <= 1'b0;
      bus_dly_q <= '0;
    end else begin
      en_sync_q <= {en_sync_q[SYNC_STAGES-2:0], bus.enable};
      en_prev_q <= en_sync_q[SYNC_STAGES-1];
      bus_dly_q <= {bus_dly_q[SYNC_STAGES-2:0], {bus.rs, bus.rw, bus.data}};
    end
  end

  assign strobe    = en_prev_q & ~en_sync_q[SYNC_STAGES-1];
  assign strb_rs   = bus_dly_q[SYNC_STAGES-1][9];
  assign strb_rw   = bus_dly_q[SYNC_STAGES-1][8];
  assign strb_data = bus_dly_q[SYNC_STAGES-1][7:0];
  assign wmap      = dd_map(ac_q);
  assign rmap      = dd_map(rd_addr);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ac_d      = ac_q;
    cgram_d   = cgram_q;
    disp_d    = disp_q;
    cur_d     = cur_q;
    blink_d   = blink_q;
    dl_d      = dl_q;
    n_d       = n_q;
    id_d      = id_q;
    ovr_d     = ovr_q;
    dd_we     = 1'b0;
    dd_widx   = clr_idx_q;
    dd_wdata  = CLEAR_FILL;
    cg_we     = 1'b0;
    cg_widx   = ac_q[5:0];
    cg_wdata  = strb_data[4:0];

    case (state_q)
      ST_CLEARING: begin
        dd_we = 1'b1;
        if (strobe && !strb_rw) ovr_d = 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ac_d    = 7'h00;
          cgram_d = 1'b0;
          id_d    = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + 7'd1;
        end
      end
      default: begin
        if (strobe && !strb_rw) begin
          if (strb_rs) begin
            if (cgram_q) begin
              cg_we = 1'b1;
            end else begin
              dd_we    = wmap[7];
              dd_widx  = wmap[6:0];
              dd_wdata = strb_data;
            end
            ac_d = ac_step(ac_q, cgram_q, id_q);
          end else begin
            casez (strb_data)
              8'b1???????: begin ac_d = strb_data[6:0]; cgram_d = 1'b0; end
              8'b01??????: begin ac_d = {1'b0, strb_data[5:0]}; cgram_d = 1'b1; end
              8'b001?????: begin dl_d = strb_data[4]; n_d = strb_data[3]; end
              8'b0001????: if (!strb_data[3]) ac_d = ac_step(ac_q, cgram_q, strb_data[2]);
              8'b00001???: begin
                disp_d  = strb_data[2];
                cur_d   = strb_data[1];
                blink_d = strb_data[0];
              end
              8'b000001??: id_d = strb_data[1];
              8'b0000001?: begin ac_d = 7'h00; cgram_d = 1'b0; end
              8'b00000001: begin state_d = ST_CLEARING; clr_idx_d = 7'h00; end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_CLEARING;
      clr_idx_q <= 7'h00;
      ac_q      <= 7'h00;
      cgram_q   <= 1'b0;
      disp_q    <= 1'b0;
      cur_q     <= 1'b0;
      blink_q   <= 1'b0;
      dl_q      <= 1'b1;
      n_q       <= 1'b0;
      id_q      <= 1'b1;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ac_q      <= ac_d;
      cgram_q   <= cgram_d;
      disp_q    <= disp_d;
      cur_q     <= cur_d;
      blink_q   <= blink_d;
      dl_q      <= dl_d;
      n_q       <= n_d;
      id_q      <= id_d;
      ovr_q     <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (dd_we) mem_q[dd_widx] <= dd_wdata;
  end

  // Free-running sweep pointer: any 64 consecutive reset cycles zero every CGRAM row.
  always_ff @(posedge clk) begin
    cg_rst_idx_q <= cg_rst_idx_q + 6'd1;
    if (!reset)     cg_q[cg_rst_idx_q] <= '0;
    else if (cg_we) cg_q[cg_widx]      <= cg_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q    <= '0;
      cg_rd_data_q <= '0;
    end else begin
      rd_data_q    <= rmap[7] ? mem_q[rmap[6:0]] : 8'h00;
      cg_rd_data_q <= cg_q[cg_rd_addr];
    end
  end

  assign rd_data      = rd_data_q;
  assign cg_rd_data   = cg_rd_data_q;
  assign addr_counter = ac_q;
  assign cgram_mode   = cgram_q;
  assign display_on   = disp_q;
  assign cursor_on    = cur_q;
  assign blink_on     = blink_q;
  assign func_dl      = dl_q;
  assign func_n       = n_q;
  assign entry_id     = id_q;
  assign busy         = (state_q == ST_CLEARING);
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed self-checking bench for lcd_hd44780_responder. It drives the LCD bus
// and checks the decoded state, the memories and the clear timing.
module tb_lcd_hd44780_responder;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] rd_addr = '0;
  logic [5:0] cg_rd_addr = '0;
  logic [7:0] rd_data;
  logic [4:0] cg_rd_data;
  logic [6:0] addr_counter;
  logic       cgram_mode, display_on, cursor_on, blink_on;
  logic       func_dl, func_n, entry_id, busy, overrun;
  int         checks = 0;
  int         errors = 0;

  localparam logic [28:0] RESET_VEC = {7'h00, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 5'h00};

  always #5 clk = ~clk;

  lcd_hd44780_responder_if bus ();

  lcd_hd44780_responder #(
    .SYNC_STAGES (2),
    .CLEAR_FILL  (8'h20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .rd_addr      (rd_addr),
    .cg_rd_addr   (cg_rd_addr),
    .rd_data      (rd_data),
    .cg_rd_data   (cg_rd_data),
    .addr_counter (addr_counter),
    .cgram_mode   (cgram_mode),
    .display_on   (display_on),
    .cursor_on    (cursor_on),
    .blink_on     (blink_on),
    .func_dl      (func_dl),
    .func_n       (func_n),
    .entry_id     (entry_id),
    .busy         (busy),
    .overrun      (overrun)
  );

  function automatic logic [28:0] out_vec();
    return {addr_counter, cgram_mode, display_on, cursor_on, blink_on,
            func_dl, func_n, entry_id, busy, overrun, rd_data, cg_rd_data};
  endfunction

  // Full bus write: the enable high and low phases each last 6 clocks.
  task automatic strobe(input logic rs_v, input logic rw_v, input logic [7:0] d);
    @(negedge clk);
    bus.rs = rs_v; bus.rw = rw_v; bus.data = d; bus.enable = 1'b1;
    repeat (6) @(negedge clk);
    bus.enable = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // Issues a clear instruction and waits until busy rises, within a bounded time.
  task automatic clear_start(output logic rose);
    int k;
    @(negedge clk);
    bus.rs = 1'b0; bus.rw = 1'b0; bus.data = 8'h01; bus.enable = 1'b1;
    repeat (6) @(negedge clk);
    bus.enable = 1'b0;
    k = 0;
    while (!busy && k < 20) begin @(negedge clk); k++; end
    rose = busy;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 300) begin n++; @(negedge clk); end
  endtask

  task automatic scan_ddram(input logic [7:0] exp, output int bad, output logic [6:0] first);
    bad = 0; first = '0;
    for (int a = 0; a < 128; a++) begin
      if (a <= 'h27 || (a >= 'h40 && a <= 'h67)) begin
        @(negedge clk); rd_addr = 7'(a);
        @(negedge clk);
        if (rd_data !== exp) begin
          if (bad == 0) first = 7'(a);
          bad++;
        end
      end
    end
  endtask

  task automatic read_dd(input logic [6:0] a, output logic [7:0] v);
    @(negedge clk); rd_addr = a;
    @(negedge clk); v = rd_data;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    repeat (70) @(negedge clk);
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++; $display("FAIL reset_values got %h exp %h", out_vec(), RESET_VEC);
    end
    reset = 1'b1;
    count_busy(n);
    checks++;
    if (n != 80) begin errors++; $display("FAIL reset_clear_len got %0d exp 80", n); end
  endtask

  task automatic test_init();
    logic rose; int n; int bad; logic [6:0] first; logic [7:0] v;
    strobe(1'b0, 1'b0, 8'h38);
    strobe(1'b0, 1'b0, 8'h0C);
    clear_start(rose);
    count_busy(n);
    checks++;
    if (!rose || n != 80) begin errors++; $display("FAIL clear_len rose %0b got %0d exp 80", rose, n); end
    checks++;
    if ({func_dl, func_n, display_on, cursor_on, blink_on} !== 5'b11100) begin
      errors++; $display("FAIL init_flags got %b exp 11100", {func_dl, func_n, display_on, cursor_on, blink_on});
    end
    checks++;
    if (addr_counter !== 7'h00) begin errors++; $display("FAIL init_ac got %h exp 00", addr_counter); end
    scan_ddram(8'h20, bad, first);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL init_fill bad %0d first addr %h exp 20", bad, first); end
    read_dd(7'h30, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL unmapped_read got %h exp 00", v); end
  endtask

  task automatic test_cgram();
    logic [7:0] wr [8] = '{8'h0A, 8'h11, 8'h1F, 8'h00, 8'h04, 8'h0E, 8'h1B, 8'hFF};
    logic [4:0] ex [8] = '{5'h0A, 5'h11, 5'h1F, 5'h00, 5'h04, 5'h0E, 5'h1B, 5'h1F};
    int bad;
    strobe(1'b0, 1'b0, 8'h40);
    foreach (wr[i]) strobe(1'b1, 1'b0, wr[i]);
    bad = 0;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk); cg_rd_addr = 6'(r);
      @(negedge clk);
      checks++;
      if (cg_rd_data !== ex[r]) begin
        errors++; $display("FAIL cgram_row%0d got %h exp %h", r, cg_rd_data, ex[r]);
      end
    end
    checks++;
    if ({addr_counter, cgram_mode} !== {7'h08, 1'b1}) begin
      errors++; $display("FAIL cgram_ac got %h/%b exp 08/1", addr_counter, cgram_mode);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    strobe(1'b0, 1'b0, 8'hC4); strobe(1'b1, 1'b0, 8'h01);
    read_dd(7'h44, v);
    checks++;
    if (v !== 8'h01 || addr_counter !== 7'h45 || cgram_mode !== 1'b0) begin
      errors++; $display("FAIL wr_44 got %h ac %h exp 01 ac 45", v, addr_counter);
    end
    strobe(1'b0, 1'b0, 8'hA7); strobe(1'b1, 1'b0, 8'h41);
    checks++;
    if (addr_counter !== 7'h40) begin errors++; $display("FAIL wrap_27 got %h exp 40", addr_counter); end
    strobe(1'b0, 1'b0, 8'hE7); strobe(1'b1, 1'b0, 8'h42);
    checks++;
    if (addr_counter !== 7'h00) begin errors++; $display("FAIL wrap_67 got %h exp 00", addr_counter); end
    strobe(1'b0, 1'b0, 8'h04); strobe(1'b0, 1'b0, 8'h80); strobe(1'b1, 1'b0, 8'h43);
    read_dd(7'h00, v);
    checks++;
    if (v !== 8'h43 || addr_counter !== 7'h67 || entry_id !== 1'b0) begin
      errors++; $display("FAIL wrap_dec00 got %h ac %h id %b exp 43 ac 67 id 0", v, addr_counter, entry_id);
    end
    read_dd(7'h27, v);
    checks++;
    if (v !== 8'h41) begin errors++; $display("FAIL cell_27 got %h exp 41", v); end
    read_dd(7'h67, v);
    checks++;
    if (v !== 8'h42) begin errors++; $display("FAIL cell_67 got %h exp 42", v); end
    strobe(1'b0, 1'b0, 8'h14);
    checks++;
    if (addr_counter !== 7'h00) begin errors++; $display("FAIL cur_right got %h exp 00", addr_counter); end
    strobe(1'b0, 1'b0, 8'h10);
    checks++;
    if (addr_counter !== 7'h67) begin errors++; $display("FAIL cur_left got %h exp 67", addr_counter); end
    strobe(1'b0, 1'b0, 8'hB0); strobe(1'b1, 1'b0, 8'h99);
    read_dd(7'h30, v);
    checks++;
    if (v !== 8'h00 || addr_counter !== 7'h2F) begin
      errors++; $display("FAIL unmapped_wr got %h ac %h exp 00 ac 2f", v, addr_counter);
    end
  endtask

  task automatic test_overrun();
    logic rose; int n; int bad; logic [6:0] first;
    clear_start(rose);
    strobe(1'b1, 1'b0, 8'h55);
    checks++;
    if (!rose || overrun !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL overrun_set got %b busy %b exp 1 1", overrun, busy);
    end
    count_busy(n);
    scan_ddram(8'h20, bad, first);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL overrun_fill bad %0d first addr %h exp 20", bad, first); end
    checks++;
    if ({addr_counter, entry_id} !== {7'h00, 1'b1}) begin
      errors++; $display("FAIL clear_exit got ac %h id %b exp 00 1", addr_counter, entry_id);
    end
    strobe(1'b0, 1'b0, 8'h85);
    strobe(1'b0, 1'b1, 8'h80);
    checks++;
    if ({addr_counter, cgram_mode, display_on, cursor_on, blink_on, func_dl, func_n, entry_id, busy, overrun}
        !== {7'h05, 1'b0, 3'b100, 2'b11, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL rw_ignored got ac %h flags %b", addr_counter,
        {cgram_mode, display_on, cursor_on, blink_on, func_dl, func_n, entry_id, busy, overrun});
    end
  endtask

  task automatic test_reset_mid();
    logic rose; int n;
    clear_start(rose);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    repeat (70) @(negedge clk);
    checks++;
    if (!rose || out_vec() !== RESET_VEC) begin
      errors++; $display("FAIL midclear_reset got %h exp %h", out_vec(), RESET_VEC);
    end
    reset = 1'b1;
    count_busy(n);
    checks++;
    if (n != 80) begin errors++; $display("FAIL midclear_len got %0d exp 80", n); end
    strobe(1'b0, 1'b0, 8'h40);
    strobe(1'b1, 1'b0, 8'h01);
    @(negedge clk);
    bus.rs = 1'b1; bus.rw = 1'b0; bus.data = 8'h02; bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus.enable = 1'b0;
    repeat (70) @(negedge clk);
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++; $display("FAIL midburst_reset got %h exp %h", out_vec(), RESET_VEC);
    end
    reset = 1'b1;
    count_busy(n);
    checks++;
    if (n != 80 || addr_counter !== 7'h00 || cgram_mode !== 1'b0) begin
      errors++; $display("FAIL midburst_len got %0d ac %h cg %b exp 80 00 0", n, addr_counter, cgram_mode);
    end
  endtask

  initial begin
    bus.rs = 1'b0; bus.rw = 1'b0; bus.enable = 1'b0; bus.data = 8'h00;
    test_reset();
    test_init();
    test_cgram();
    test_wrap();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
